pattern_stream_scanner: RTL
===========================

# pattern_stream_scanner

Word-to-serial scan controller for the 110110 bit-stream pattern detector. It accepts parallel words over a valid/ready handshake and shifts them MSB-first, one bit per clock, into an embedded overlapping pattern matcher. It counts matches, flags each one, and raises a sticky interrupt at a programmable threshold. It sits between a byte-wide producer (FIFO/bus slave) and the status/interrupt logic.

## Interface
- DATA_W, 8, input word width (≥ 2)
- PAT_W, 6, pattern length in bits
- PATTERN, 6'b110110, bit pattern; leftmost bit arrives first
- CNT_W, 16, match counter width
- IRQ_THRESH, 4, match count at which irq is set (1 .. 2^CNT_W−1)
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  level; permits acceptance of new words
- clear  in  1  single-cycle pulse; zeroes count, irq and pattern history
- in_valid  in  1  producer has a word
- in_data  in  DATA_W  word; in_data[DATA_W−1] is shifted first
- in_ready  out  1  block can accept a word this cycle
- ser_bit  out  1  bit currently presented to the matcher
- busy  out  1  high while in SHIFT
- match  out  1  one-cycle pulse per completed pattern occurrence
- match_count  out  CNT_W  saturating count of matches
- irq  out  1  sticky; set when match_count reaches IRQ_THRESH

## Operation
- FSM states: IDLE and SHIFT. bit_cnt has $clog2(DATA_W) bits.
- IDLE: in_ready = enable. On in_valid&&in_ready, load shreg ← in_data, set bit_cnt ← 0, and go to SHIFT.
- SHIFT: each cycle ser_bit = shreg[DATA_W−1]. The bit is fed to the matcher, then shreg shifts left and bit_cnt increments.
- On the last bit (bit_cnt == DATA_W−1): in_ready = enable.
  - If a word is accepted that cycle, reload and stay in SHIFT with bit_cnt ← 0. Back-to-back words give gap-free streaming.
  - Otherwise go to IDLE.
- enable deasserted mid-word: the current word finishes. Only acceptance of new words is blocked.
- Matcher:
  - PAT_W-bit history register and saturating fill counter. A match needs ≥ PAT_W bits seen since reset/clear.
  - Condition: {hist[PAT_W−2:0], ser_bit} == PATTERN.
  - Overlapping occurrences all count; history persists across word boundaries.
- match is registered: it pulses in the cycle after the completing bit. match_count increments on the same edge and saturates at 2^CNT_W−1 (no wrap).
- irq is set on the edge where match_count becomes IRQ_THRESH. It stays set (including through saturation) until clear or rst.
- clear: zeroes match_count, irq, history and fill count. Shifting of the current word continues.
  - A match completing in the same cycle as clear is discarded: no pulse, no count.
- ser_bit = 0 in IDLE.

## Timing
- Reset values: in_ready 0 during rst, then enable-driven; busy 0; ser_bit 0; match 0; match_count 0; irq 0; FSM IDLE; history empty.
- rst mid-word: the partial word is discarded and nothing resumes.
- Word accepted at edge T: bit k (k = 0 is the MSB) is presented during cycle T+1+k.
- A match completing at bit k pulses match during cycle T+2+k.
- Throughput: one word per DATA_W cycles when back-to-back.

## Structure
- Shared package: FSM state enum (IDLE, SHIFT), default PATTERN and PAT_W constants.
- One sub-module, pattern_bit_matcher (parameters PAT_W, PATTERN). It holds the history register, fill counter and registered match output. Inputs: bit_valid, bit, clear.
- Top level holds the FSM, shift register, handshake, counter and irq.

## Test plan
- Reset: rst pulse mid-SHIFT gives busy 0, match_count 0, irq 0, no match. The next accepted word is scanned from its MSB.
- Single word 0xDB (11011011) accepted at T, then idle: exactly one match pulse at T+7; match_count = 1; busy high T+1..T+8.
- Back-to-back 0xDB then 0x6C, with in_valid held:
  - second word accepted at T+8;
  - match pulses at T+7, T+10, T+13, T+16 (overlap across the boundary);
  - count = 4; irq rises at T+16 with IRQ_THRESH = 4.
- clear asserted in the cycle of bit index 11 of the above stream:
  - no pulse at T+13 and count is 0 after clear;
  - the match at T+16 is not produced, because history was cleared (fewer than 6 bits seen);
  - irq stays 0.
- enable low during word 1: word 1 completes, in_ready stays 0 and in_valid is ignored. Raising enable resumes acceptance in IDLE.
- CNT_W = 2, IRQ_THRESH = 3, repeated 0xDB/0x6C stream: count reaches 3 and stays 3, irq stays 1, match still pulses per occurrence.

Source files
------------

// File: rtl/pattern_stream_scanner_pkg.sv
// Shared types and default pattern constants for the pattern stream scanner.
package pattern_stream_scanner_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } scan_state_e;

   localparam int unsigned        DefPatW    = 6;
   localparam logic [DefPatW-1:0] DefPattern = 6'b110110;

endpackage

// File: rtl/pattern_bit_matcher.sv
// Overlapping serial pattern matcher: history window, fill counter, registered match pulse.
module pattern_bit_matcher
   import pattern_stream_scanner_pkg::*;
#(
   parameter int unsigned      PAT_W   = DefPatW,
   parameter logic [PAT_W-1:0] PATTERN = DefPattern
) (
   input  logic clk,
   input  logic rst,
   input  logic bit_valid_i,
   input  logic bit_i,
   input  logic clear_i,
   output logic hit_o,
   output logic match_o
);

   localparam int unsigned      FillW    = $clog2(PAT_W + 1);
   localparam logic [FillW-1:0] FillFull = FillW'(PAT_W);
   localparam logic [FillW-1:0] FillPrev = FillW'(PAT_W - 1);

   // Only the previous PAT_W-1 bits are kept; the live bit completes the window.
   logic [PAT_W-2:0] hist_q, hist_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic [PAT_W-1:0] window;
   logic             match_q;

   assign window = {hist_q, bit_i};

   always_comb begin
      hist_d = hist_q;
      fill_d = fill_q;
      hit_o  = 1'b0;
      if (clear_i) begin
         // A match completing with clear is dropped along with the history.
         hist_d = '0;
         fill_d = '0;
      end else if (bit_valid_i) begin
         hit_o  = (fill_q >= FillPrev) && (window == PATTERN);
         hist_d = window[PAT_W-2:0];
         if (fill_q != FillFull) begin
            fill_d = fill_q + FillW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q  <= '0;
         fill_q  <= '0;
         match_q <= 1'b0;
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         match_q <= hit_o;
      end
   end

   assign match_o = match_q;

endmodule

// File: rtl/pattern_stream_scanner.sv
// Word-to-serial scan controller feeding an overlapping pattern matcher,
// with a saturating match counter and a sticky threshold interrupt.
module pattern_stream_scanner
   import pattern_stream_scanner_pkg::*;
#(
   parameter int unsigned      DATA_W     = 8,
   parameter int unsigned      PAT_W      = DefPatW,
   parameter logic [PAT_W-1:0] PATTERN    = DefPattern,
   parameter int unsigned      CNT_W      = 16,
   parameter int unsigned      IRQ_THRESH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              clear_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] in_data_i,
   output logic              in_ready_o,
   output logic              ser_bit_o,
   output logic              busy_o,
   output logic              match_o,
   output logic [CNT_W-1:0]  match_count_o,
   output logic              irq_o
);

   localparam int unsigned        BitCntW = $clog2(DATA_W);
   localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);
   localparam logic [CNT_W-1:0]   CntMax  = '1;
   localparam logic [CNT_W-1:0]   Thresh  = CNT_W'(IRQ_THRESH);

   scan_state_e         state_q;
   logic [DATA_W-1:0]   shreg_q;
   logic [BitCntW-1:0]  bit_cnt_q;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                irq_q, irq_d;
   logic                last_bit;
   logic                accept;
   logic                hit;

   assign last_bit = (state_q == StShift) && (bit_cnt_q == LastBit);

   // Ready in IDLE or on the final bit, so back-to-back words stream gap-free.
   assign in_ready_o = !rst && enable_i && ((state_q == StIdle) || last_bit);
   assign accept     = in_valid_i && in_ready_o;

   assign busy_o    = (state_q == StShift);
   assign ser_bit_o = busy_o && shreg_q[DATA_W-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  shreg_q   <= in_data_i;
                  bit_cnt_q <= '0;
                  state_q   <= StShift;
               end
            end
            StShift: begin
               if (accept) begin
                  shreg_q   <= in_data_i;
                  bit_cnt_q <= '0;
               end else begin
                  shreg_q   <= {shreg_q[DATA_W-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                  if (last_bit) begin
                     state_q <= StIdle;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   pattern_bit_matcher #(
      .PAT_W   (PAT_W),
      .PATTERN (PATTERN)
   ) u_matcher (
      .clk         (clk),
      .rst         (rst),
      .bit_valid_i (busy_o),
      .bit_i       (ser_bit_o),
      .clear_i     (clear_i),
      .hit_o       (hit),
      .match_o     (match_o)
   );

   always_comb begin
      count_d = count_q;
      irq_d   = irq_q;
      if (clear_i) begin
         count_d = '0;
         irq_d   = 1'b0;
      end else if (hit && (count_q != CntMax)) begin
         count_d = count_q + CNT_W'(1);
         if (count_d == Thresh) begin
            irq_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
         irq_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         irq_q   <= irq_d;
      end
   end

   assign match_count_o = count_q;
   assign irq_o         = irq_q;

endmodule
